// File: rtl/rob_nway.sv
// N-way reorder buffer: in-order dispatch and retire of up to WAY entries per cycle,
// CDB_PORTS out-of-order completions per cycle, full flush when a mispredict retires.
module rob_nway #(
   parameter int ROB_SIZE  = 32,
   parameter int ROB_LEN   = $clog2(ROB_SIZE),
   parameter int WAY       = 2,
   parameter int CDB_PORTS = 2,
   parameter int PRF_LEN   = 6,
   parameter int XLEN      = 32
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [WAY-1:0]                    dispatch_valid,
   input  logic [WAY-1:0][XLEN-1:0]          dispatch_pc,
   input  logic [WAY-1:0][4:0]               dispatch_dest_areg,
   input  logic [WAY-1:0][PRF_LEN-1:0]       dispatch_dest_preg,
   output logic [WAY-1:0][ROB_LEN-1:0]       dispatch_rob_idx,
   output logic [ROB_LEN:0]                  rob_free_count,
   input  logic [CDB_PORTS-1:0]              cdb_valid,
   input  logic [CDB_PORTS-1:0][ROB_LEN-1:0] cdb_rob_idx,
   input  logic [CDB_PORTS-1:0]              cdb_mis_pred,
   output logic [WAY-1:0]                    commit_valid,
   output logic [WAY-1:0][XLEN-1:0]          commit_pc,
   output logic [WAY-1:0][4:0]               commit_dest_areg,
   output logic [WAY-1:0][PRF_LEN-1:0]       commit_dest_preg,
   output logic                              mis_pred_is_head,
   output logic [ROB_LEN-1:0]                rob_head,
   output logic [ROB_LEN-1:0]                rob_tail,
   output logic                              rob_empty,
   output logic                              rob_full
);

   localparam logic [ROB_LEN:0] SIZE = (ROB_LEN+1)'(ROB_SIZE);
   localparam logic [ROB_LEN:0] ONE  = (ROB_LEN+1)'(1);

   logic [ROB_SIZE-1:0]         valid_q, valid_d, exec_q, exec_d, mp_q, mp_d;
   logic [XLEN-1:0]             pc_q   [ROB_SIZE];
   logic [XLEN-1:0]             pc_d   [ROB_SIZE];
   logic [4:0]                  areg_q [ROB_SIZE];
   logic [4:0]                  areg_d [ROB_SIZE];
   logic [PRF_LEN-1:0]          preg_q [ROB_SIZE];
   logic [PRF_LEN-1:0]          preg_d [ROB_SIZE];
   logic [ROB_LEN-1:0]          head_q, head_d, tail_q, tail_d;
   logic [ROB_LEN:0]            count_q, count_d, n_commit, n_disp;
   logic [WAY-1:0]              disp_acc;
   logic [WAY-1:0][ROB_LEN-1:0] commit_idx;
   logic                        commit_run;

   assign rob_head       = head_q;
   assign rob_tail       = tail_q;
   assign rob_empty      = (count_q == '0);
   assign rob_full       = (count_q == SIZE);
   assign rob_free_count = SIZE - count_q;

   // Retire group: oldest-first prefix of executed entries, cut after a mispredict.
   always_comb begin
      commit_valid     = '0;
      commit_pc        = '0;
      commit_dest_areg = '0;
      commit_dest_preg = '0;
      commit_idx       = '0;
      mis_pred_is_head = 1'b0;
      n_commit         = '0;
      commit_run       = 1'b1;
      for (int i = 0; i < WAY; i++) begin
         commit_idx[i] = head_q + ROB_LEN'(i);
         if (commit_run && valid_q[commit_idx[i]] && exec_q[commit_idx[i]]) begin
            commit_valid[i]     = 1'b1;
            commit_pc[i]        = pc_q[commit_idx[i]];
            commit_dest_areg[i] = areg_q[commit_idx[i]];
            commit_dest_preg[i] = preg_q[commit_idx[i]];
            n_commit            = n_commit + ONE;
            if (mp_q[commit_idx[i]]) begin
               mis_pred_is_head = 1'b1;
               commit_run       = 1'b0;
            end
         end else begin
            commit_run = 1'b0;
         end
      end
   end

   // Free space comes from registered count only, so same-cycle retires never help.
   always_comb begin
      disp_acc         = '0;
      n_disp           = '0;
      dispatch_rob_idx = '0;
      for (int i = 0; i < WAY; i++) begin
         dispatch_rob_idx[i] = tail_q + ROB_LEN'(i);
         if (dispatch_valid[i] && ((ROB_LEN+1)'(i) < rob_free_count)) begin
            disp_acc[i] = 1'b1;
            n_disp      = n_disp + ONE;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      exec_d  = exec_q;
      mp_d    = mp_q;
      pc_d    = pc_q;
      areg_d  = areg_q;
      preg_d  = preg_q;
      head_d  = head_q + n_commit[ROB_LEN-1:0];
      tail_d  = tail_q + n_disp[ROB_LEN-1:0];
      count_d = count_q + n_disp - n_commit;
      for (int p = 0; p < CDB_PORTS; p++) begin
         if (cdb_valid[p] && valid_q[cdb_rob_idx[p]]) begin
            exec_d[cdb_rob_idx[p]] = 1'b1;
            mp_d[cdb_rob_idx[p]]   = mp_d[cdb_rob_idx[p]] | cdb_mis_pred[p];
         end
      end
      for (int i = 0; i < WAY; i++) begin
         if (commit_valid[i]) begin
            valid_d[commit_idx[i]] = 1'b0;
            exec_d[commit_idx[i]]  = 1'b0;
            mp_d[commit_idx[i]]    = 1'b0;
         end
      end
      for (int i = 0; i < WAY; i++) begin
         if (disp_acc[i]) begin
            valid_d[dispatch_rob_idx[i]] = 1'b1;
            exec_d[dispatch_rob_idx[i]]  = 1'b0;
            mp_d[dispatch_rob_idx[i]]    = 1'b0;
            pc_d[dispatch_rob_idx[i]]    = dispatch_pc[i];
            areg_d[dispatch_rob_idx[i]]  = dispatch_dest_areg[i];
            preg_d[dispatch_rob_idx[i]]  = dispatch_dest_preg[i];
         end
      end
      if (mis_pred_is_head) begin
         valid_d = '0;
         exec_d  = '0;
         mp_d    = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         exec_q  <= '0;
         mp_q    <= '0;
         pc_q    <= '{default: '0};
         areg_q  <= '{default: '0};
         preg_q  <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         exec_q  <= exec_d;
         mp_q    <= mp_d;
         pc_q    <= pc_d;
         areg_q  <= areg_d;
         preg_q  <= preg_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: doc/rob_nway.md
# rob_nway

Parametrised N-way reorder buffer, successor to the single-issue ROB. It accepts up to `WAY` in-order dispatches per cycle and completes up to `CDB_PORTS` executions per cycle. It retires up to `WAY` in-order instructions per cycle to the RRAT and freelist. A mispredicted branch flushes the buffer when it reaches commit. It sits between the dispatch stage (RS/RAT/freelist) and the RRAT, and its completion ports are driven by the CDB.

## Interface
- `ROB_SIZE`, 32, entry count; power of two, at least 2·`WAY`.
- `ROB_LEN`, $clog2(`ROB_SIZE`), entry index width.
- `WAY`, 2, dispatch and commit width.
- `CDB_PORTS`, 2, completion ports per cycle.
- `PRF_LEN`, 6, physical register index width.
- `XLEN`, 32, PC width.

Ports:
- `clock` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `dispatch_valid` in `WAY`: per-slot dispatch request; must be a prefix (slot i valid ⇒ slots 0..i-1 valid).
- `dispatch_pc` in `WAY`×`XLEN`: PC per slot.
- `dispatch_dest_areg` in `WAY`×5: architectural destination per slot.
- `dispatch_dest_preg` in `WAY`×`PRF_LEN`: allocated physical destination per slot.
- `dispatch_rob_idx` out `WAY`×`ROB_LEN`: entry assigned to slot i = (tail+i) mod `ROB_SIZE`.
- `rob_free_count` out `ROB_LEN`+1: free entries, from registered state only.
- `cdb_valid` in `CDB_PORTS`: completion valid per port.
- `cdb_rob_idx` in `CDB_PORTS`×`ROB_LEN`: completing entry.
- `cdb_mis_pred` in `CDB_PORTS`: completing branch was mispredicted.
- `commit_valid` out `WAY`: slot i retires this cycle; always a prefix.
- `commit_pc` / `commit_dest_areg` / `commit_dest_preg` out `WAY`×(`XLEN`/5/`PRF_LEN`): retiring entry fields, slot 0 = oldest.
- `mis_pred_is_head` out 1: a retiring slot is mispredicted; flush at this edge.
- `rob_head`, `rob_tail` out `ROB_LEN`: pointers; `rob_empty`, `rob_full` out 1: count==0 / count==`ROB_SIZE`.

## Operation
- State: per-entry {valid, executed, mis_pred, pc, areg, preg}; head, tail, count (`ROB_LEN`+1 bits).
- Dispatch: accepted = min(popcount(`dispatch_valid`), `rob_free_count`); accepted slots write entries tail..tail+accepted-1 with valid=1, executed=0, mis_pred=0; tail += accepted mod `ROB_SIZE`. Slots beyond free count are dropped silently. Same-cycle commits do not increase the free space.
- Completion: for each port with `cdb_valid`, if the target entry is valid, set executed=1 and mis_pred |= `cdb_mis_pred`. A port targeting an invalid entry is ignored. Two ports hitting the same entry OR their mis_pred bits. Completion targeting an entry dispatched in the same cycle is ignored.
- Commit (combinational from registered state): slot i commits iff entry head+i is valid and executed, all lower slots commit, and no lower slot is mispredicted. Retired entries are cleared; head += committed; count += accepted − committed.
- Flush: if `mis_pred_is_head`, the mispredicted entry and the older entries in the same group still commit (outputs valid). At the edge: head=tail=count=0, all entries invalid. Dispatch and completion that cycle are discarded.
- Pointers wrap modulo `ROB_SIZE`; commit groups may straddle index `ROB_SIZE`-1→0.

## Timing
- Reset values:
  - head = tail = 0, count = 0
  - `rob_empty` = 1, `rob_full` = 0, `rob_free_count` = `ROB_SIZE`
  - `commit_valid` = 0, `mis_pred_is_head` = 0, all entries invalid
  - `dispatch_rob_idx[i]` = i; `commit_*` data = 0
- Dispatch in cycle n is visible (valid) from cycle n+1; completion in cycle n+1 sets executed at its end; `commit_valid` is asserted in cycle n+2 at earliest. The buffer is 2-cycle minimum dispatch→retire.
- `commit_*`, `mis_pred_is_head`, `rob_free_count`, `dispatch_rob_idx` depend only on registered state (no input→output combinational path).
- Full: `rob_free_count`=0, all dispatch dropped; commits still proceed. Empty: `commit_valid`=0.
- Reset deassertion is synchronous to design use; reset asserted mid-operation clears everything with no commit.

## Test plan
- Reset, `WAY`=2, `ROB_SIZE`=8: dispatch 2/cycle for 4 cycles (PC 0x0..0x1c) → tail 0,2,4,6,0; `rob_full`=1, `rob_free_count`=0; a 5th dispatch is dropped, tail stays 0.
- Complete entries 1 then 0 via two CDB ports in one cycle → next cycle `commit_valid`=2'b11, PCs 0x0/0x4, head 0→2, count 8→6.
- Complete only entry 1 → `commit_valid`=0 (head entry 0 not executed); then complete 0 → both retire next cycle.
- Entry 0 completes with `cdb_mis_pred`=1 while entry 1 is also executed → `commit_valid`=2'b01, `mis_pred_is_head`=1; next cycle head=tail=0, `rob_empty`=1, a same-cycle dispatch is not allocated.
- Wrap: head=6, tail=6; dispatch 4 → entries 6,7,0,1; complete all; commits 6,7 then 0,1; tail=2.
- Assert `reset`=0 mid-stream with 5 entries live → immediately `rob_empty`=1, `commit_valid`=0, pointers 0.
